// File: rtl/ifu_if.sv
// Instruction-fetch memory bus: request/accept channel and
// response channel between the fetch unit and instruction memory.
interface ifu_if;
   logic        mem_req_valid;
   logic        mem_req_ready;
   logic [31:0] mem_req_addr;
   logic        mem_rsp_valid;
   logic [31:0] mem_rsp_data;
   logic        mem_rsp_err;

   modport master (
      output mem_req_valid,
      output mem_req_addr,
      input  mem_req_ready,
      input  mem_rsp_valid,
      input  mem_rsp_data,
      input  mem_rsp_err
   );

   modport slave (
      input  mem_req_valid,
      input  mem_req_addr,
      output mem_req_ready,
      output mem_rsp_valid,
      output mem_rsp_data,
      output mem_rsp_err
   );
endinterface

// File: rtl/ifu.sv
// Instruction fetch unit: one outstanding fetch at a time,
// holds the fetched word until the core supplies the next PC.
module ifu #(
   parameter logic [31:0] RESET_PC = 32'h8000_0000,
   parameter int unsigned TIMEOUT  = 255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] pc_in,
   input  logic        pc_we,
   output logic [31:0] pc_out,
   output logic [31:0] inst_out,
   output logic        inst_valid,
   ifu_if.master       mem,
   output logic        fetch_err,
   output logic [31:0] fetch_cnt
);

   typedef enum logic [2:0] {
      IDLE,
      REQ,
      WAIT,
      HOLD,
      ERR
   } state_t;

   localparam logic [15:0] TO_LIM = 16'(TIMEOUT);

   state_t      state;
   logic        req_q;
   logic [15:0] wcnt;

   // The request strobe and address come straight from flops,
   // so no memory input can reach them combinationally.
   assign mem.mem_req_valid = req_q;
   assign mem.mem_req_addr  = pc_out;

   // Fetch sequencer; ERR is left only through reset.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= IDLE;
         req_q      <= 1'b0;
         pc_out     <= RESET_PC;
         inst_out   <= '0;
         inst_valid <= 1'b0;
         fetch_err  <= 1'b0;
         fetch_cnt  <= '0;
         wcnt       <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               state <= REQ;
               req_q <= 1'b1;
            end
            REQ: begin
               if (mem.mem_req_ready) begin
                  state <= WAIT;
                  req_q <= 1'b0;
                  wcnt  <= '0;
               end
            end
            WAIT: begin
               // A response in the final cycle beats the timeout.
               if (mem.mem_rsp_valid) begin
                  if (mem.mem_rsp_err) begin
                     state     <= ERR;
                     fetch_err <= 1'b1;
                  end else begin
                     state      <= HOLD;
                     inst_out   <= mem.mem_rsp_data;
                     inst_valid <= 1'b1;
                     fetch_cnt  <= fetch_cnt + 32'd1;
                  end
               end else if (wcnt + 16'd1 == TO_LIM) begin
                  state     <= ERR;
                  fetch_err <= 1'b1;
               end else begin
                  wcnt <= wcnt + 16'd1;
               end
            end
            HOLD: begin
               if (pc_we) begin
                  pc_out     <= pc_in;
                  inst_valid <= 1'b0;
                  if (pc_in[1:0] == 2'b00) begin
                     state <= REQ;
                     req_q <= 1'b1;
                  end else begin
                     state     <= ERR;
                     fetch_err <= 1'b1;
                  end
               end
            end
            ERR: begin
               inst_valid <= 1'b0;
               fetch_err  <= 1'b1;
            end
            default: begin
               state <= IDLE;
               req_q <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ifu.sv
// Self-checking bench for ifu: directed scenarios plus a
// randomized fetch stream checked against a transaction model.
module tb_ifu;
   localparam logic [31:0] RST_PC = 32'h8000_0000;
   localparam int          TO     = 3;

   logic        clk;
   logic        rst;
   logic [31:0] pc_in;
   logic        pc_we;
   logic [31:0] pc_out;
   logic [31:0] inst_out;
   logic        inst_valid;
   logic        fetch_err;
   logic [31:0] fetch_cnt;

   int checks = 0;
   int errors = 0;

   ifu_if bus ();

   ifu #(
      .RESET_PC(RST_PC),
      .TIMEOUT (TO)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .pc_in     (pc_in),
      .pc_we     (pc_we),
      .pc_out    (pc_out),
      .inst_out  (inst_out),
      .inst_valid(inst_valid),
      .mem       (bus),
      .fetch_err (fetch_err),
      .fetch_cnt (fetch_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      bus.mem_req_ready = 1'b0;
      bus.mem_rsp_valid = 1'b0;
      bus.mem_rsp_err   = 1'b0;
      bus.mem_rsp_data  = '0;
      pc_we             = 1'b0;
      pc_in             = '0;
   endtask

   // Reset released just after an edge; DUT sits in IDLE.
   task automatic do_reset();
      idle_inputs();
      rst = 1'b0;
      step();
      step();
      rst = 1'b1;
   endtask

   // From the first REQ cycle: accept, respond, land in HOLD.
   task automatic fetch_one(input logic [31:0] d);
      bus.mem_req_ready = 1'b1;
      step();
      bus.mem_req_ready = 1'b0;
      bus.mem_rsp_valid = 1'b1;
      bus.mem_rsp_data  = d;
      step();
      bus.mem_rsp_valid = 1'b0;
   endtask

   task automatic test_reset();
      idle_inputs();
      rst = 1'b0;
      step();
      checks++; if (pc_out !== RST_PC) begin errors++; $display("FAIL rst_pc got %h exp %h", pc_out, RST_PC); end
      checks++; if (inst_out !== 32'h0) begin errors++; $display("FAIL rst_inst got %h exp 0", inst_out); end
      checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL rst_ivalid got %b exp 0", inst_valid); end
      checks++; if (bus.mem_req_valid !== 1'b0) begin errors++; $display("FAIL rst_reqv got %b exp 0", bus.mem_req_valid); end
      checks++; if (fetch_err !== 1'b0) begin errors++; $display("FAIL rst_err got %b exp 0", fetch_err); end
      checks++; if (fetch_cnt !== 32'h0) begin errors++; $display("FAIL rst_cnt got %h exp 0", fetch_cnt); end
      rst = 1'b1;
      step();
      checks++; if (bus.mem_req_valid !== 1'b1) begin errors++; $display("FAIL rst_first_req got %b exp 1", bus.mem_req_valid); end
      checks++; if (bus.mem_req_addr !== RST_PC) begin errors++; $display("FAIL rst_first_addr got %h exp %h", bus.mem_req_addr, RST_PC); end
   endtask

   task automatic test_basic();
      do_reset();
      step();
      checks++; if (bus.mem_req_addr !== 32'h8000_0000) begin errors++; $display("FAIL basic_addr got %h exp 80000000", bus.mem_req_addr); end
      bus.mem_req_ready = 1'b1;
      step();
      bus.mem_req_ready = 1'b0;
      checks++; if (bus.mem_req_valid !== 1'b0) begin errors++; $display("FAIL basic_reqv_wait got %b exp 0", bus.mem_req_valid); end
      checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL basic_early_valid got %b exp 0", inst_valid); end
      bus.mem_rsp_valid = 1'b1;
      bus.mem_rsp_data  = 32'h0010_0073;
      step();
      bus.mem_rsp_valid = 1'b0;
      checks++; if (inst_valid !== 1'b1) begin errors++; $display("FAIL basic_valid got %b exp 1", inst_valid); end
      checks++; if (inst_out !== 32'h0010_0073) begin errors++; $display("FAIL basic_inst got %h exp 00100073", inst_out); end
      checks++; if (fetch_cnt !== 32'd1) begin errors++; $display("FAIL basic_cnt got %0d exp 1", fetch_cnt); end
   endtask

   task automatic test_stall();
      do_reset();
      step();
      for (int c = 0; c < 5; c++) begin
         checks++; if ({bus.mem_req_valid, bus.mem_req_addr} !== {1'b1, RST_PC}) begin errors++; $display("FAIL stall_hold c%0d got %b/%h exp 1/%h", c, bus.mem_req_valid, bus.mem_req_addr, RST_PC); end
         step();
      end
      bus.mem_req_ready = 1'b1;
      step();
      bus.mem_req_ready = 1'b1;
      checks++; if (bus.mem_req_valid !== 1'b0) begin errors++; $display("FAIL stall_dup got %b exp 0", bus.mem_req_valid); end
      step();
      bus.mem_req_ready = 1'b0;
      checks++; if (bus.mem_req_valid !== 1'b0) begin errors++; $display("FAIL stall_dup2 got %b exp 0", bus.mem_req_valid); end
      bus.mem_rsp_valid = 1'b1;
      bus.mem_rsp_data  = 32'hCAFE_0013;
      step();
      bus.mem_rsp_valid = 1'b0;
      checks++; if (fetch_cnt !== 32'd1) begin errors++; $display("FAIL stall_cnt got %0d exp 1", fetch_cnt); end
   endtask

   task automatic test_redirect();
      do_reset();
      step();
      fetch_one(32'h0000_0013);
      pc_we = 1'b1;
      pc_in = 32'h8000_0010;
      step();
      pc_we = 1'b0;
      checks++; if (bus.mem_req_valid !== 1'b1) begin errors++; $display("FAIL redir_reqv got %b exp 1", bus.mem_req_valid); end
      checks++; if (bus.mem_req_addr !== 32'h8000_0010) begin errors++; $display("FAIL redir_addr got %h exp 80000010", bus.mem_req_addr); end
      checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL redir_ivalid got %b exp 0", inst_valid); end
      bus.mem_req_ready = 1'b1;
      step();
      bus.mem_req_ready = 1'b0;
      pc_we = 1'b1;
      pc_in = 32'h1234_5678;
      step();
      pc_we = 1'b0;
      checks++; if (pc_out !== 32'h8000_0010) begin errors++; $display("FAIL redir_wait_we got %h exp 80000010", pc_out); end
      bus.mem_rsp_valid = 1'b1;
      bus.mem_rsp_data  = 32'h0020_0093;
      step();
      bus.mem_rsp_valid = 1'b0;
      checks++; if ({inst_valid, inst_out} !== {1'b1, 32'h0020_0093}) begin errors++; $display("FAIL redir_fetch got %b/%h exp 1/00200093", inst_valid, inst_out); end
      checks++; if (fetch_cnt !== 32'd2) begin errors++; $display("FAIL redir_cnt got %0d exp 2", fetch_cnt); end
   endtask

   task automatic test_errors();
      do_reset();
      step();
      fetch_one(32'h0000_0013);
      pc_we = 1'b1;
      pc_in = 32'h8000_0006;
      step();
      checks++; if (fetch_err !== 1'b1) begin errors++; $display("FAIL mis_err got %b exp 1", fetch_err); end
      checks++; if (pc_out !== 32'h8000_0006) begin errors++; $display("FAIL mis_pc got %h exp 80000006", pc_out); end
      pc_in = 32'h8000_0020;
      bus.mem_req_ready = 1'b1;
      for (int c = 0; c < 3; c++) begin
         checks++; if ({bus.mem_req_valid, inst_valid} !== 2'b00) begin errors++; $display("FAIL mis_quiet c%0d got %b%b exp 00", c, bus.mem_req_valid, inst_valid); end
         step();
      end
      do_reset();
      step();
      bus.mem_req_ready = 1'b1;
      step();
      bus.mem_req_ready = 1'b0;
      bus.mem_rsp_valid = 1'b1;
      bus.mem_rsp_err   = 1'b1;
      bus.mem_rsp_data  = 32'h0000_0013;
      step();
      idle_inputs();
      checks++; if ({fetch_err, inst_valid} !== 2'b10) begin errors++; $display("FAIL rsperr got %b%b exp 10", fetch_err, inst_valid); end
      checks++; if (fetch_cnt !== 32'd0) begin errors++; $display("FAIL rsperr_cnt got %0d exp 0", fetch_cnt); end
   endtask

   task automatic test_timeout();
      do_reset();
      step();
      bus.mem_req_ready = 1'b1;
      step();
      bus.mem_req_ready = 1'b0;
      for (int w = 1; w <= TO; w++) begin
         checks++; if (fetch_err !== 1'b0) begin errors++; $display("FAIL to_early w%0d got %b exp 0", w, fetch_err); end
         step();
      end
      checks++; if (fetch_err !== 1'b1) begin errors++; $display("FAIL to_err got %b exp 1", fetch_err); end
      bus.mem_rsp_valid = 1'b1;
      bus.mem_rsp_data  = 32'h0000_0013;
      step();
      bus.mem_rsp_valid = 1'b0;
      checks++; if ({inst_valid, fetch_cnt} !== 33'h0) begin errors++; $display("FAIL to_late got %b/%0d exp 0/0", inst_valid, fetch_cnt); end
      do_reset();
      step();
      bus.mem_req_ready = 1'b1;
      step();
      bus.mem_req_ready = 1'b0;
      step();
      step();
      bus.mem_rsp_valid = 1'b1;
      bus.mem_rsp_data  = 32'h0030_0113;
      step();
      bus.mem_rsp_valid = 1'b0;
      checks++; if ({fetch_err, inst_valid} !== 2'b01) begin errors++; $display("FAIL to_race got %b%b exp 01", fetch_err, inst_valid); end
      checks++; if (inst_out !== 32'h0030_0113) begin errors++; $display("FAIL to_race_inst got %h exp 00300113", inst_out); end
   endtask

   task automatic test_reset_in_wait();
      do_reset();
      step();
      fetch_one(32'h0000_0013);
      pc_we = 1'b1;
      pc_in = 32'h8000_0100;
      step();
      pc_we = 1'b0;
      bus.mem_req_ready = 1'b1;
      step();
      bus.mem_req_ready = 1'b0;
      #2;
      rst = 1'b0;
      #1;
      checks++; if (pc_out !== RST_PC) begin errors++; $display("FAIL arst_pc got %h exp %h", pc_out, RST_PC); end
      checks++; if ({inst_out, fetch_cnt} !== 64'h0) begin errors++; $display("FAIL arst_regs got %h/%h exp 0/0", inst_out, fetch_cnt); end
      checks++; if ({inst_valid, fetch_err, bus.mem_req_valid} !== 3'b000) begin errors++; $display("FAIL arst_flags got %b%b%b exp 000", inst_valid, fetch_err, bus.mem_req_valid); end
      bus.mem_rsp_valid = 1'b1;
      bus.mem_rsp_data  = 32'hDEAD_BEEF;
      step();
      rst = 1'b1;
      step();
      step();
      bus.mem_rsp_valid = 1'b0;
      checks++; if ({inst_valid, fetch_cnt} !== 33'h0) begin errors++; $display("FAIL arst_drop got %b/%0d exp 0/0", inst_valid, fetch_cnt); end
      checks++; if ({bus.mem_req_valid, bus.mem_req_addr} !== {1'b1, RST_PC}) begin errors++; $display("FAIL arst_restart got %b/%h exp 1/%h", bus.mem_req_valid, bus.mem_req_addr, RST_PC); end
   endtask

   // Transaction model: each fetch either completes, errors
   // on a bad response, times out after TO silent WAIT
   // cycles, or dies on a misaligned redirect.
   task automatic test_random();
      logic [31:0] exp_pc;
      logic [31:0] exp_cnt;
      logic [31:0] data;
      logic [31:0] nxt;
      int          stall;
      int          dly;
      bit          bad;
      bit          dead;
      for (int run = 0; run < 8; run++) begin
         do_reset();
         step();
         exp_pc  = RST_PC;
         exp_cnt = 0;
         dead    = 1'b0;
         data    = '0;
         for (int f = 0; f < 20 && !dead; f++) begin
            stall = $urandom_range(0, 3);
            for (int c = 0; c <= stall; c++) begin
               checks++; if ({bus.mem_req_valid, bus.mem_req_addr} !== {1'b1, exp_pc}) begin errors++; $display("FAIL rnd_req r%0d f%0d got %b/%h exp 1/%h", run, f, bus.mem_req_valid, bus.mem_req_addr, exp_pc); end
               bus.mem_rsp_valid = 1'($urandom_range(0, 1));
               pc_we             = 1'($urandom_range(0, 1));
               pc_in             = $urandom;
               bus.mem_req_ready = (c == stall);
               step();
            end
            idle_inputs();
            dly = $urandom_range(0, TO + 1);
            bad = ($urandom_range(0, 7) == 0);
            for (int w = 1; w <= TO; w++) begin
               checks++; if ({bus.mem_req_valid, fetch_err, inst_valid} !== 3'b000) begin errors++; $display("FAIL rnd_wait r%0d f%0d got %b%b%b exp 000", run, f, bus.mem_req_valid, fetch_err, inst_valid); end
               if (w == dly + 1) begin
                  data              = $urandom;
                  bus.mem_rsp_valid = 1'b1;
                  bus.mem_rsp_err   = bad;
                  bus.mem_rsp_data  = data;
               end else begin
                  pc_we = 1'($urandom_range(0, 1));
                  pc_in = $urandom;
               end
               step();
               idle_inputs();
               if (w == dly + 1) break;
            end
            if (dly + 1 > TO || bad) begin
               checks++; if ({fetch_err, inst_valid, fetch_cnt} !== {2'b10, exp_cnt}) begin errors++; $display("FAIL rnd_err r%0d f%0d got %b%b/%0d exp 10/%0d", run, f, fetch_err, inst_valid, fetch_cnt, exp_cnt); end
               dead = 1'b1;
            end else begin
               exp_cnt = exp_cnt + 1;
               checks++; if ({inst_valid, fetch_err, inst_out, fetch_cnt, pc_out} !== {2'b10, data, exp_cnt, exp_pc}) begin errors++; $display("FAIL rnd_done r%0d f%0d got %b%b/%h/%0d/%h exp 10/%h/%0d/%h", run, f, inst_valid, fetch_err, inst_out, fetch_cnt, pc_out, data, exp_cnt, exp_pc); end
               for (int h = $urandom_range(0, 2); h > 0; h--) begin
                  bus.mem_rsp_valid = 1'b1;
                  bus.mem_rsp_data  = $urandom;
                  step();
                  idle_inputs();
                  checks++; if ({inst_valid, inst_out, pc_out, bus.mem_req_valid} !== {1'b1, data, exp_pc, 1'b0}) begin errors++; $display("FAIL rnd_hold r%0d f%0d got %b/%h/%h exp 1/%h/%h", run, f, inst_valid, inst_out, pc_out, data, exp_pc); end
               end
               nxt = $urandom;
               if ($urandom_range(0, 9) != 0) nxt[1:0] = 2'b00;
               pc_we = 1'b1;
               pc_in = nxt;
               step();
               idle_inputs();
               checks++; if ({pc_out, inst_valid} !== {nxt, 1'b0}) begin errors++; $display("FAIL rnd_redir r%0d f%0d got %h/%b exp %h/0", run, f, pc_out, inst_valid, nxt); end
               if (nxt[1:0] != 2'b00) begin
                  checks++; if ({fetch_err, bus.mem_req_valid} !== 2'b10) begin errors++; $display("FAIL rnd_mis r%0d f%0d got %b%b exp 10", run, f, fetch_err, bus.mem_req_valid); end
                  dead = 1'b1;
               end
               exp_pc = nxt;
            end
         end
         if (dead) begin
            bus.mem_req_ready = 1'b1;
            pc_we             = 1'b1;
            pc_in             = 32'h8000_0040;
            for (int c = 0; c < 2; c++) begin
               step();
               checks++; if ({fetch_err, inst_valid, bus.mem_req_valid} !== 3'b100) begin errors++; $display("FAIL rnd_absorb r%0d got %b%b%b exp 100", run, fetch_err, inst_valid, bus.mem_req_valid); end
            end
            idle_inputs();
         end
      end
   endtask

   initial begin
      rst = 1'b0;
      idle_inputs();
      test_reset();
      test_basic();
      test_stall();
      test_redirect();
      test_errors();
      test_timeout();
      test_reset_in_wait();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
